// File: rtl/corrimiento_iterativo.sv
// Multi-cycle ARM-style shifter/rotator: LSL/LSR/ASR/ROR/RRX/PASS with carry-out,
// shifting at most STEP bits per clock behind a valid/ready handshake.
module corrimiento_iterativo #(
  parameter int N    = 32,
  parameter int SW   = 8,
  parameter int STEP = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a,
  input  logic [SW-1:0] b,
  input  logic [2:0]    mode,
  input  logic          carry_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  z,
  output logic          carry_out
);

  localparam int RW = $clog2(N + 2);
  localparam int EW = (SW > RW) ? SW : RW;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [2:0] {OP_LSL, OP_LSR, OP_ASR, OP_ROR, OP_RRX, OP_PASS} op_t;

  state_t        state, state_nx;
  op_t           op_q, op_in;
  logic          fill_q, fill_in;
  logic [RW-1:0] rem_q, eff, k;
  logic [EW-1:0] b_ext, b_mod;
  logic [N-1:0]  z_nx;
  logic          c_nx;

  // Request decode: operation, effective amount and the bit shifted in from the MSB
  always_comb begin
    op_in   = OP_PASS;
    eff     = '0;
    fill_in = 1'b0;
    b_ext   = EW'(b);
    b_mod   = b_ext & EW'(N - 1);
    unique case (mode)
      3'b000:  op_in = OP_LSL;
      3'b001:  op_in = OP_LSR;
      3'b010:  op_in = OP_ASR;
      3'b011:  op_in = OP_ROR;
      3'b100:  op_in = OP_RRX;
      default: op_in = OP_PASS;
    endcase
    case (op_in)
      OP_LSL, OP_LSR, OP_ASR:
        eff = (b_ext > EW'(N + 1)) ? RW'(N + 1) : RW'(b_ext);
      OP_ROR:
        eff = (b_mod == '0 && b_ext != '0) ? RW'(N) : RW'(b_mod);
      OP_RRX:
        eff = RW'(1);
      default:
        eff = '0;
    endcase
    if (op_in == OP_ASR) fill_in = a[N-1];
    else if (op_in == OP_RRX) fill_in = carry_in;
  end

  // One clock of shifting: k single-bit steps, carry tracks the last bit out
  always_comb begin
    k    = (rem_q > RW'(STEP)) ? RW'(STEP) : rem_q;
    z_nx = z;
    c_nx = carry_out;
    for (int unsigned i = 0; i < STEP; i++) begin
      if (RW'(i) < k) begin
        case (op_q)
          OP_LSL: begin
            c_nx = z_nx[N-1];
            z_nx = {z_nx[N-2:0], 1'b0};
          end
          OP_ROR: begin
            c_nx = z_nx[0];
            z_nx = {z_nx[0], z_nx[N-1:1]};
          end
          default: begin
            c_nx = z_nx[0];
            z_nx = {fill_q, z_nx[N-1:1]};
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid) state_nx = (eff != '0) ? SHIFT : DONE;
      end
      SHIFT: begin
        if (rem_q == k) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      z         <= '0;
      carry_out <= 1'b0;
      rem_q     <= '0;
      op_q      <= OP_PASS;
      fill_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            z         <= a;
            carry_out <= carry_in;
            rem_q     <= eff;
            op_q      <= op_in;
            fill_q    <= fill_in;
          end
        end
        SHIFT: begin
          z         <= z_nx;
          carry_out <= c_nx;
          rem_q     <= rem_q - k;
        end
        default: ;
      endcase
    end
  end

endmodule
